// File: rtl/rv32i_types.sv
// Shared types for the cache-line memory arbiter: line/address widths,
// arbiter state encoding and last-grant encoding.
package rv32i_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// Define CACHELINE_ARBITER_RR_EN for round-robin on contention (default: D-cache wins).
module cacheline_arbiter
  import rv32i_types::*;
(
  input  logic                clk,
  input  logic                rst,

  input  logic                icache_read,
  input  logic [ADDR_W-1:0]   icache_address,
  output logic [LINE_W-1:0]   icache_rdata,
  output logic                icache_resp,

  input  logic                dcache_read,
  input  logic                dcache_write,
  input  logic [ADDR_W-1:0]   dcache_address,
  input  logic [LINE_W-1:0]   dcache_wdata,
  output logic [LINE_W-1:0]   dcache_rdata,
  output logic                dcache_resp,

  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  arb_state_t state_q, state_d;
  logic       i_req;
  logic       d_req;
  logic       pick_d;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

  assign icache_rdata = mem_rdata;
  assign dcache_rdata = mem_rdata;

`ifdef CACHELINE_ARBITER_RR_EN
  grant_t last_grant_q, last_grant_d;

  // On contention, hand the port to whichever side did not get it last.
  assign pick_d = (last_grant_q == GRANT_I);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= GRANT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
`ifdef CACHELINE_ARBITER_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = pick_d ? SERVE_D : SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end
`ifdef CACHELINE_ARBITER_RR_EN
        if (state_d == SERVE_D) begin
          last_grant_d = GRANT_D;
        end else if (state_d == SERVE_I) begin
          last_grant_d = GRANT_I;
        end
`endif
      end

      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = icache_address;
        icache_resp = mem_resp;
        // Always pass through IDLE so a requester dropping after resp is not re-served.
        if (mem_resp) begin
          state_d = IDLE;
        end
      end

      SERVE_D: begin
        mem_read    = dcache_read & ~dcache_write;
        mem_write   = dcache_write;
        mem_address = dcache_address;
        mem_wdata   = dcache_wdata;
        dcache_resp = mem_resp;
        if (mem_resp) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
